// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage and its neighbours.
//   - Pipeline bus widths (stall vector, IF->ID bus, branch bus)
//   - Stall encoding (STOP / NO_STOP)
//   - Boot vector RESET_PC and the pre-boot PC value held during reset
//   - Fetch FSM state encodings
//   - Packed views of the branch and IF->ID buses
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int STALL_WD    = 6;
    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    // One word below the boot vector so decode sees a consistent "previous"
    // PC while ce is still low.
    localparam logic [31:0] PRE_RESET_PC = 32'hBFBF_FFFC;

    localparam logic [31:0] PC_STEP = 32'd4;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: owns the PC, presents fetch addresses to the
// instruction SRAM and hands {ce, pc} to decode. SRAM read data for pc_reg
// arrives one cycle after the address was presented, so the address output
// runs one PC ahead of if_to_id_bus while the pipe is moving.
//
// Branches from decode that arrive while this stage is stalled are parked in
// pend_addr and taken on the first unstalled cycle; a live branch on that
// cycle wins over the parked one.
//
// Optional feature (macro FETCH_ADEL_EN): flag misaligned fetch PCs on
// fetch_adel and suppress the SRAM enable for the misaligned address.
//
// Ports
//   clk             in   system clock
//   rst             in   synchronous, active-high reset
//   stall           in   pipeline stall vector, bit 0 governs this stage
//   br_bus          in   {br_e, br_addr[31:0]} from decode
//   if_to_id_bus    out  {ce, pc[31:0]} to decode
//   inst_sram_en    out  instruction SRAM enable
//   inst_sram_wen   out  byte write enables, always 4'b0000
//   inst_sram_addr  out  fetch address
//   inst_sram_wdata out  always 32'b0
//   fetch_adel      out  misaligned-PC flag (FETCH_ADEL_EN only)
// -----------------------------------------------------------------------------
// state | meaning
// BOOT  | out of reset; next edge loads RESET_PC and raises ce
// RUN   | normal fetch; PC advances unless stall[0] is STOP
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_WD-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata
`ifdef FETCH_ADEL_EN
    ,
    output logic                   fetch_adel
`endif
);

    logic [0:0]  state;
    logic [31:0] pc_reg;
    logic        ce_reg;
    logic        pend_valid;
    logic [31:0] pend_addr;

    br_bus_t     br;
    if_to_id_t   if_to_id;
    logic        stop_here;
    logic [31:0] next_pc;

    // Upper stall bits belong to later stages.
    logic        unused_stall;
    assign unused_stall = ^stall[STALL_WD-1:1];

    assign br        = br_bus;
    assign stop_here = (stall[0] == STOP);

    // Live branch beats a parked one; otherwise sequential, wrapping at 2^32.
    always_comb begin
        next_pc = pc_reg + PC_STEP;
        if (br.br_e) begin
            next_pc = br.br_addr;
        end else if (pend_valid) begin
            next_pc = pend_addr;
        end
    end

    always_comb begin
        inst_sram_addr = RESET_PC;
        if (state == ST_RUN) begin
            inst_sram_addr = stop_here ? pc_reg : next_pc;
        end
    end

`ifdef FETCH_ADEL_EN
    always_comb begin
        inst_sram_en = ~rst & ~is_misaligned(inst_sram_addr);
    end
`else
    always_comb begin
        inst_sram_en = ~rst;
    end
`endif

    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'b0;

    assign if_to_id.ce  = ce_reg;
    assign if_to_id.pc  = pc_reg;
    assign if_to_id_bus = if_to_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BOOT;
            pc_reg     <= PRE_RESET_PC;
            ce_reg     <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= 32'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    // Stall is deliberately ignored here: the boot fetch
                    // must always be issued.
                    state      <= ST_RUN;
                    pc_reg     <= RESET_PC;
                    ce_reg     <= 1'b1;
                    pend_valid <= 1'b0;
                end
                ST_RUN: begin
                    if (stop_here) begin
                        // Latest branch during a stall overwrites earlier ones.
                        if (br.br_e) begin
                            pend_valid <= 1'b1;
                            pend_addr  <= br.br_addr;
                        end
                    end else begin
                        pc_reg     <= next_pc;
                        pend_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_ADEL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_adel <= 1'b0;
        end else if (state == ST_BOOT) begin
            fetch_adel <= is_misaligned(RESET_PC);
        end else if (!stop_here) begin
            fetch_adel <= is_misaligned(next_pc);
        end
    end
`endif

endmodule
